// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - SPI frame decoder turning byte streams into register reads/writes
// Frame = command, ADDR_BYTES address bytes (MSB first), then auto-incrementing data bytes.
module spi_cmd_decoder #(
   parameter int ADDR_BYTES = 2,
   parameter int RD_TIMEOUT = 255,
   localparam int AW = 8 * ADDR_BYTES
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          rx_stream_sof,
   input  logic [7:0]    rx_stream_data,
   input  logic          rx_stream_vld,
   input  logic          rx_stream_eof,
   output logic          reg_wr,
   output logic          reg_rd,
   output logic [AW-1:0] reg_addr,
   output logic [7:0]    reg_wdata,
   input  logic [7:0]    reg_rdata,
   input  logic          reg_rdata_vld,
   output logic [7:0]    tx_send_data,
   output logic [23:0]   tx_send_momment,
   output logic          tx_send_valid,
   output logic          frame_done,
   output logic          frame_err
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDWAIT, RDIDLE, DROP} state_t;

   state_t        state;
   state_t        byte_state;
   logic          is_rd;
   logic [1:0]    acnt;
   logic [AW-1:0] addr;
   logic [AW+7:0] addr_shift;
   logic [23:0]   byte_cnt;
   logic          rd_pend;
   logic [23:0]   slot;
   logic [7:0]    tmo_cnt;
   logic          tmo_hit;
   logic          rd_done;
   logic          addr_last;

   assign addr_shift = {addr, rx_stream_data};
   assign tmo_hit    = (tmo_cnt == 8'(RD_TIMEOUT - 1));
   assign rd_done    = (state == RDWAIT) && (reg_rdata_vld || tmo_hit);
   assign addr_last  = (acnt == 2'(ADDR_BYTES - 1));

   // State after the current byte / read completion, before eof closes the frame.
   always_comb begin
      byte_state = state;
      case (state)
         CMD: if (rx_stream_vld)
            byte_state = (rx_stream_data == 8'h02 || rx_stream_data == 8'h03) ? ADDR : DROP;
         ADDR: if (rx_stream_vld && addr_last)
            byte_state = is_rd ? RDWAIT : WDATA;
         RDWAIT: if (rd_done)
            byte_state = RDIDLE;
         RDIDLE: if (rx_stream_vld || rd_pend)
            byte_state = RDWAIT;
         default: byte_state = state;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state           <= IDLE;
         is_rd           <= 1'b0;
         acnt            <= '0;
         addr            <= '0;
         byte_cnt        <= '0;
         rd_pend         <= 1'b0;
         slot            <= '0;
         tmo_cnt         <= '0;
         reg_wr          <= 1'b0;
         reg_rd          <= 1'b0;
         reg_addr        <= '0;
         reg_wdata       <= '0;
         tx_send_data    <= '0;
         tx_send_momment <= '0;
         tx_send_valid   <= 1'b0;
         frame_done      <= 1'b0;
         frame_err       <= 1'b0;
      end else begin
         reg_wr        <= 1'b0;
         reg_rd        <= 1'b0;
         tx_send_valid <= 1'b0;
         frame_done    <= 1'b0;
         frame_err     <= 1'b0;
         if (rx_stream_sof) begin
            // A new sof outside IDLE means the previous eof was lost.
            if (state != IDLE)
               frame_err <= 1'b1;
            state    <= CMD;
            byte_cnt <= '0;
            acnt     <= '0;
            addr     <= '0;
            is_rd    <= 1'b0;
            rd_pend  <= 1'b0;
            slot     <= 24'(ADDR_BYTES + 1);
         end else begin
            if (rx_stream_vld && byte_cnt != 24'hFFFFFF)
               byte_cnt <= byte_cnt + 24'd1;
            case (state)
               CMD: if (rx_stream_vld) begin
                  is_rd <= (rx_stream_data == 8'h03);
                  if (rx_stream_data != 8'h02 && rx_stream_data != 8'h03)
                     frame_err <= 1'b1;
               end
               ADDR: if (rx_stream_vld) begin
                  addr <= addr_shift[AW-1:0];
                  acnt <= acnt + 2'd1;
                  if (addr_last && is_rd) begin
                     reg_rd   <= 1'b1;
                     reg_addr <= addr_shift[AW-1:0];
                     tmo_cnt  <= '0;
                  end
               end
               WDATA: if (rx_stream_vld) begin
                  reg_wr    <= 1'b1;
                  reg_wdata <= rx_stream_data;
                  reg_addr  <= addr;
                  addr      <= addr + 1'b1;
               end
               RDWAIT: begin
                  if (rx_stream_vld) begin
                     if (rd_pend)
                        frame_err <= 1'b1;
                     rd_pend <= 1'b1;
                  end
                  if (rd_done) begin
                     tx_send_valid   <= 1'b1;
                     tx_send_data    <= reg_rdata_vld ? reg_rdata : 8'hFF;
                     tx_send_momment <= slot;
                     slot            <= slot + 24'd1;
                     addr            <= addr + 1'b1;
                     if (!reg_rdata_vld)
                        frame_err <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt + 8'd1;
                  end
               end
               RDIDLE: if (rx_stream_vld || rd_pend) begin
                  rd_pend  <= 1'b0;
                  reg_rd   <= 1'b1;
                  reg_addr <= addr;
                  tmo_cnt  <= '0;
               end
               default: ;
            endcase
            if (rx_stream_eof) begin
               case (byte_state)
                  WDATA, RDWAIT, RDIDLE: frame_done <= 1'b1;
                  CMD, ADDR:             frame_err  <= 1'b1;
                  default: ;
               endcase
               state <= IDLE;
            end else begin
               state <= byte_state;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - directed self-checking bench for spi_cmd_decoder
module tb_spi_cmd_decoder;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_stream_sof = 1'b0;
   logic [7:0]  rx_stream_data = 8'h00;
   logic        rx_stream_vld = 1'b0;
   logic        rx_stream_eof = 1'b0;
   logic        reg_wr, reg_rd;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata = 8'h00;
   logic        reg_rdata_vld = 1'b0;
   logic [7:0]  tx_send_data;
   logic [23:0] tx_send_momment;
   logic        tx_send_valid, frame_done, frame_err;

   always #5 clock = ~clock;

   spi_cmd_decoder #(.ADDR_BYTES(2), .RD_TIMEOUT(255)) dut (
      .clock(clock), .rst_n(rst_n),
      .rx_stream_sof(rx_stream_sof), .rx_stream_data(rx_stream_data),
      .rx_stream_vld(rx_stream_vld), .rx_stream_eof(rx_stream_eof),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_rdata_vld(reg_rdata_vld),
      .tx_send_data(tx_send_data), .tx_send_momment(tx_send_momment),
      .tx_send_valid(tx_send_valid), .frame_done(frame_done), .frame_err(frame_err)
   );

   typedef struct {logic [23:0] a; logic [7:0] d; int c;} ev_t;
   ev_t wr_q[$], rd_q[$], tx_q[$];
   int  done_n, err_n, both_n, cyc, vld_cyc, n_chk, n_fail;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (reg_wr) wr_q.push_back('{24'(reg_addr), reg_wdata, cyc});
      if (reg_rd) rd_q.push_back('{24'(reg_addr), 8'h00, cyc});
      if (tx_send_valid) tx_q.push_back('{tx_send_momment, tx_send_data, cyc});
      if (frame_done) done_n++;
      if (frame_err) err_n++;
      if (reg_wr && reg_rd) both_n++;
   end

   function automatic ev_t at(input ev_t q[$], input int i);
      ev_t e;
      e = '{24'h0, 8'h0, -1};
      if (i < q.size()) e = q[i];
      return e;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input logic [7:0] b, input logic e);
      rx_stream_data = b;
      rx_stream_vld  = 1'b1;
      rx_stream_eof  = e;
      vld_cyc        = cyc;
      tick();
      rx_stream_vld  = 1'b0;
      rx_stream_eof  = 1'b0;
   endtask

   task automatic start();
      rx_stream_sof = 1'b1;
      tick();
      rx_stream_sof = 1'b0;
   endtask

   task automatic close_frame();
      rx_stream_eof = 1'b1;
      tick();
      rx_stream_eof = 1'b0;
      tick();
      tick();
   endtask

   task automatic clear_logs();
      wr_q.delete();
      rd_q.delete();
      tx_q.delete();
      done_n = 0;
      err_n  = 0;
   endtask

   task automatic wait_rd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (reg_rd) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic respond(input logic [7:0] d, output int c);
      reg_rdata     = d;
      reg_rdata_vld = 1'b1;
      c             = cyc;
      tick();
      reg_rdata_vld = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_chk++;
      if ({reg_wr, reg_rd, reg_addr, reg_wdata, tx_send_data, tx_send_momment,
           tx_send_valid, frame_done, frame_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: wr=%b rd=%b addr=%h txv=%b done=%b err=%b, required all 0",
                  reg_wr, reg_rd, reg_addr, tx_send_valid, frame_done, frame_err);
      end
      rst_n = 1'b1;
      tick();
      clear_logs();
   endtask

   task automatic test_write();
      int v1, v2;
      ev_t e0, e1;
      clear_logs();
      start();
      put(8'h02, 0); put(8'h12, 0); put(8'h34, 0);
      put(8'hAA, 0); v1 = vld_cyc;
      put(8'hBB, 0); v2 = vld_cyc;
      close_frame();
      e0 = at(wr_q, 0);
      e1 = at(wr_q, 1);
      n_chk++;
      if (wr_q.size() != 2) begin n_fail++; $display("FAIL write_count: got %0d, required 2", wr_q.size()); end
      n_chk++;
      if ({e0.a, e0.d} !== {24'h001234, 8'hAA} || e0.c != v1 + 1) begin
         n_fail++; $display("FAIL write_first: addr=%h data=%h cyc=%0d, required 1234/AA/%0d", e0.a, e0.d, e0.c, v1 + 1);
      end
      n_chk++;
      if ({e1.a, e1.d} !== {24'h001235, 8'hBB} || e1.c != v2 + 1) begin
         n_fail++; $display("FAIL write_second: addr=%h data=%h cyc=%0d, required 1235/BB/%0d", e1.a, e1.d, e1.c, v2 + 1);
      end
      n_chk++;
      if (done_n != 1 || err_n != 0) begin
         n_fail++; $display("FAIL write_pulses: done=%0d err=%0d, required 1/0", done_n, err_n);
      end
   endtask

   task automatic test_read();
      bit ok1, ok2;
      int r1, r2;
      ev_t t0, t1;
      clear_logs();
      start();
      put(8'h03, 0); put(8'h00, 0); put(8'h10, 0);
      wait_rd(ok1);
      tick(); tick(); tick();
      respond(8'h5A, r1);
      put(8'h00, 0);
      wait_rd(ok2);
      tick(); tick(); tick();
      respond(8'h5B, r2);
      close_frame();
      t0 = at(tx_q, 0);
      t1 = at(tx_q, 1);
      n_chk++;
      if (!(ok1 && ok2)) begin n_fail++; $display("FAIL read_strobe_seen: got %b%b, required 11", ok1, ok2); end
      n_chk++;
      if (rd_q.size() != 2 || at(rd_q, 0).a !== 24'h000010 || at(rd_q, 1).a !== 24'h000011) begin
         n_fail++; $display("FAIL read_addrs: n=%0d a0=%h a1=%h, required 2/0010/0011",
                            rd_q.size(), at(rd_q, 0).a, at(rd_q, 1).a);
      end
      n_chk++;
      if (tx_q.size() != 2 || {t0.d, t0.a} !== {8'h5A, 24'd3} || t0.c != r1 + 1) begin
         n_fail++; $display("FAIL read_tx_first: n=%0d data=%h mom=%0d cyc=%0d, required 2/5A/3/%0d",
                            tx_q.size(), t0.d, t0.a, t0.c, r1 + 1);
      end
      n_chk++;
      if ({t1.d, t1.a} !== {8'h5B, 24'd4} || t1.c != r2 + 1) begin
         n_fail++; $display("FAIL read_tx_second: data=%h mom=%0d cyc=%0d, required 5B/4/%0d", t1.d, t1.a, t1.c, r2 + 1);
      end
      n_chk++;
      if (done_n != 1 || err_n != 0) begin
         n_fail++; $display("FAIL read_pulses: done=%0d err=%0d, required 1/0", done_n, err_n);
      end
   endtask

   task automatic test_read_pending();
      bit ok1, ok2;
      int r1, r2;
      clear_logs();
      start();
      put(8'h03, 0); put(8'h00, 0); put(8'h40, 0);
      wait_rd(ok1);
      put(8'h00, 0);
      put(8'h00, 0);
      respond(8'h11, r1);
      wait_rd(ok2);
      tick();
      respond(8'h22, r2);
      close_frame();
      n_chk++;
      if (!(ok1 && ok2) || rd_q.size() != 2 || at(rd_q, 1).a !== 24'h000041) begin
         n_fail++; $display("FAIL pend_reads: seen=%b%b n=%0d a1=%h, required 11/2/0041",
                            ok1, ok2, rd_q.size(), at(rd_q, 1).a);
      end
      n_chk++;
      if ({at(tx_q, 0).d, at(tx_q, 0).a, at(tx_q, 1).d, at(tx_q, 1).a} !== {8'h11, 24'd3, 8'h22, 24'd4}) begin
         n_fail++; $display("FAIL pend_tx: %h@%0d %h@%0d, required 11@3 22@4",
                            at(tx_q, 0).d, at(tx_q, 0).a, at(tx_q, 1).d, at(tx_q, 1).a);
      end
      n_chk++;
      if (done_n != 1 || err_n != 1) begin
         n_fail++; $display("FAIL pend_pulses: done=%0d err=%0d, required 1/1", done_n, err_n);
      end
   endtask

   task automatic test_wrap();
      clear_logs();
      start();
      put(8'h02, 0); put(8'hFF, 0); put(8'hFF, 0); put(8'h11, 0); put(8'h22, 0);
      close_frame();
      n_chk++;
      if (wr_q.size() != 2 || at(wr_q, 0).a !== 24'h00FFFF || at(wr_q, 1).a !== 24'h000000 ||
          at(wr_q, 1).d !== 8'h22) begin
         n_fail++; $display("FAIL wrap_addr: n=%0d a0=%h a1=%h d1=%h, required 2/FFFF/0000/22",
                            wr_q.size(), at(wr_q, 0).a, at(wr_q, 1).a, at(wr_q, 1).d);
      end
   endtask

   task automatic test_errors();
      clear_logs();
      start();
      put(8'h7F, 0); put(8'h12, 0); put(8'h34, 0); put(8'h56, 0);
      close_frame();
      n_chk++;
      if (err_n != 1 || done_n != 0 || wr_q.size() != 0 || rd_q.size() != 0) begin
         n_fail++; $display("FAIL bad_cmd: err=%0d done=%0d wr=%0d rd=%0d, required 1/0/0/0",
                            err_n, done_n, wr_q.size(), rd_q.size());
      end
      clear_logs();
      start();
      put(8'h02, 0); put(8'h12, 0);
      close_frame();
      n_chk++;
      if (err_n != 1 || done_n != 0 || wr_q.size() != 0) begin
         n_fail++; $display("FAIL short_frame: err=%0d done=%0d wr=%0d, required 1/0/0", err_n, done_n, wr_q.size());
      end
      clear_logs();
      start();
      put(8'h02, 0); put(8'h12, 0);
      start();
      put(8'h02, 0); put(8'h00, 0); put(8'h05, 0); put(8'h77, 0);
      close_frame();
      n_chk++;
      if (err_n != 1 || done_n != 1 || wr_q.size() != 1 || {at(wr_q, 0).a, at(wr_q, 0).d} !== {24'h000005, 8'h77}) begin
         n_fail++; $display("FAIL sof_midframe: err=%0d done=%0d wr=%0d a=%h d=%h, required 1/1/1/0005/77",
                            err_n, done_n, wr_q.size(), at(wr_q, 0).a, at(wr_q, 0).d);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      clear_logs();
      start();
      put(8'h03, 0); put(8'h00, 0); put(8'h10, 0);
      wait_rd(ok);
      for (int i = 0; i < 300 && tx_q.size() == 0; i++) tick();
      n_chk++;
      if (!ok || tx_q.size() != 1 || {at(tx_q, 0).d, at(tx_q, 0).a} !== {8'hFF, 24'd3} ||
          at(tx_q, 0).c - at(rd_q, 0).c != 255) begin
         n_fail++; $display("FAIL timeout_push: seen=%b n=%0d data=%h mom=%0d delay=%0d, required 1/1/FF/3/255",
                            ok, tx_q.size(), at(tx_q, 0).d, at(tx_q, 0).a, at(tx_q, 0).c - at(rd_q, 0).c);
      end
      close_frame();
      n_chk++;
      if (err_n != 1 || done_n != 1) begin
         n_fail++; $display("FAIL timeout_pulses: err=%0d done=%0d, required 1/1", err_n, done_n);
      end
   endtask

   task automatic test_reset_mid_write();
      clear_logs();
      start();
      put(8'h02, 0); put(8'h12, 0); put(8'h34, 0); put(8'hAA, 0);
      rst_n = 1'b0;
      tick();
      n_chk++;
      if ({reg_wr, reg_rd, reg_addr, reg_wdata, tx_send_valid, frame_done, frame_err} !== '0) begin
         n_fail++; $display("FAIL midreset_outputs: wr=%b addr=%h wdata=%h, required 0/0000/00", reg_wr, reg_addr, reg_wdata);
      end
      rst_n = 1'b1;
      tick();
      clear_logs();
      put(8'hBB, 0); put(8'hCC, 0);
      close_frame();
      n_chk++;
      if (wr_q.size() != 0 || done_n != 0 || err_n != 0) begin
         n_fail++; $display("FAIL midreset_ignore: wr=%0d done=%0d err=%0d, required 0/0/0", wr_q.size(), done_n, err_n);
      end
   endtask

   task automatic test_back_to_back();
      clear_logs();
      start();
      put(8'h02, 0); put(8'h00, 0); put(8'h20, 0); put(8'hC3, 1);
      start();
      put(8'h02, 0); put(8'hAB, 0); put(8'hCD, 0); put(8'h5E, 1);
      tick(); tick();
      n_chk++;
      if (wr_q.size() != 2 || {at(wr_q, 0).a, at(wr_q, 0).d, at(wr_q, 1).a, at(wr_q, 1).d} !==
          {24'h000020, 8'hC3, 24'h00ABCD, 8'h5E}) begin
         n_fail++; $display("FAIL eof_with_byte: n=%0d %h/%h %h/%h, required 2 0020/C3 ABCD/5E",
                            wr_q.size(), at(wr_q, 0).a, at(wr_q, 0).d, at(wr_q, 1).a, at(wr_q, 1).d);
      end
      n_chk++;
      if (done_n != 2 || err_n != 0) begin
         n_fail++; $display("FAIL b2b_pulses: done=%0d err=%0d, required 2/0", done_n, err_n);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_pending();
      test_wrap();
      test_errors();
      test_timeout();
      test_reset_mid_write();
      test_back_to_back();
      n_chk++;
      if (both_n != 0) begin
         n_fail++; $display("FAIL wr_rd_exclusive: got %0d overlaps, required 0", both_n);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
